// File: rtl/axis_cabs_multilane.sv
// rtl/axis_cabs_multilane.sv - multi-lane |I+jQ| stage with peak-channel index on tuser
// Define AXIS_CABS_PEAK_IDX_EN to compile in the peak comparator; otherwise m_axis_tuser is 0.

module math_cabs_core #(
  parameter int W     = 16,
  parameter int DELAY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ena,
  input  logic [W-1:0] i_re,
  input  logic [W-1:0] i_im,
  output logic [W-1:0] o_abs
);
  logic signed [2*W-1:0] w_re_ext, w_im_ext;
  logic [2*W-1:0] w_sum;
  logic [W-1:0]   w_root;

  // Exact floor(sqrt(I^2+Q^2)), digit-by-digit; the sum always fits 2W bits unsigned.
  function automatic logic [W-1:0] isqrt(input logic [2*W-1:0] v);
    logic [2*W-1:0] op, res, bitv;
    op   = v;
    res  = '0;
    bitv = (2*W)'(1) << (2*W-2);
    for (int i = 0; i < W; i++) begin
      if (op >= res + bitv) begin
        op  = op - res - bitv;
        res = (res >> 1) + bitv;
      end else begin
        res = res >> 1;
      end
      bitv = bitv >> 2;
    end
    return res[W-1:0];
  endfunction

  assign w_re_ext = (2*W)'($signed(i_re));
  assign w_im_ext = (2*W)'($signed(i_im));
  assign w_sum    = $unsigned(w_re_ext * w_re_ext + w_im_ext * w_im_ext);
  assign w_root   = isqrt(w_sum);

  if (DELAY == 0) begin : g_comb
    assign o_abs = w_root;
  end else begin : g_pipe
    logic [W-1:0] r_pipe [DELAY];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DELAY; i++) r_pipe[i] <= '0;
      end else if (i_ena) begin
        r_pipe[0] <= w_root;
        for (int i = 1; i < DELAY; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign o_abs = r_pipe[DELAY-1];
  end
endmodule

module math_cabs_16 #(
  parameter int DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ena,
  input  logic [15:0] i_re,
  input  logic [15:0] i_im,
  output logic [15:0] o_abs
);
  math_cabs_core #(.W(16), .DELAY(DELAY)) u_core (
    .clk(clk), .rst(rst), .i_ena(i_ena), .i_re(i_re), .i_im(i_im), .o_abs(o_abs));
endmodule

module math_cabs_32 #(
  parameter int DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ena,
  input  logic [31:0] i_re,
  input  logic [31:0] i_im,
  output logic [31:0] o_abs
);
  math_cabs_core #(.W(32), .DELAY(DELAY)) u_core (
    .clk(clk), .rst(rst), .i_ena(i_ena), .i_re(i_re), .i_im(i_im), .o_abs(o_abs));
endmodule

module axis_cabs_multilane #(
  parameter  int NUM_CHANNELS  = 8,
  parameter  int CHANNEL_WIDTH = 32,
  parameter  int NUM_LANES     = 2,
  parameter  int CABS_DELAY    = 1,
  localparam int DATA_WIDTH    = NUM_CHANNELS * CHANNEL_WIDTH,
  localparam int COUNT_WIDTH   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata_abs,
  output logic                   m_axis_tlast,
  output logic [COUNT_WIDTH-1:0] m_axis_tuser
);
  localparam int S         = NUM_CHANNELS / NUM_LANES;
  localparam int HW        = CHANNEL_WIDTH / 2;
  localparam int ABS_WIDTH = (CHANNEL_WIDTH <= 32) ? 16 : 32;
  localparam int SW        = (S > 1) ? $clog2(S) : 1;
  localparam logic [SW-1:0] LAST_SLICE = SW'(S - 1);

  typedef enum logic [1:0] {IDLE, CALC, DRAIN, HOLD} state_t;

  state_t                r_state, w_state_nxt;
  logic [SW-1:0]         r_slice;
  logic [DATA_WIDTH-1:0] r_data, r_abs, w_abs_nxt;
  logic                  r_last;
  logic                  w_ena, w_accept, w_ret_vld, w_ret_final;
  logic [SW-1:0]         w_ret_idx;
  logic [ABS_WIDTH-1:0]  w_lane_abs [NUM_LANES];

  assign s_axis_tready = (r_state == IDLE) && !rst;
  assign w_accept      = (r_state == IDLE) && s_axis_tvalid;
  assign w_ret_final   = w_ret_vld && (w_ret_idx == LAST_SLICE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ena       = 1'b0;
    case (r_state)
      IDLE:  if (s_axis_tvalid) w_state_nxt = CALC;
      CALC: begin
        w_ena = 1'b1;
        if (w_ret_final)               w_state_nxt = HOLD;
        else if (r_slice == LAST_SLICE) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_ena = 1'b1;
        if (w_ret_final) w_state_nxt = HOLD;
      end
      HOLD:    if (m_axis_tvalid && m_axis_tready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [HW-1:0]        w_re_raw, w_im_raw;
    logic [ABS_WIDTH-1:0] w_re, w_im;
    assign w_re_raw = r_data[(int'(r_slice) * NUM_LANES + l) * CHANNEL_WIDTH +: HW];
    assign w_im_raw = r_data[(int'(r_slice) * NUM_LANES + l) * CHANNEL_WIDTH + HW +: HW];
    assign w_re     = ABS_WIDTH'($signed(w_re_raw));
    assign w_im     = ABS_WIDTH'($signed(w_im_raw));
    if (ABS_WIDTH == 16) begin : g_c16
      math_cabs_16 #(.DELAY(CABS_DELAY)) u_cabs (
        .clk(clk), .rst(rst), .i_ena(w_ena), .i_re(w_re), .i_im(w_im), .o_abs(w_lane_abs[l]));
    end else begin : g_c32
      math_cabs_32 #(.DELAY(CABS_DELAY)) u_cabs (
        .clk(clk), .rst(rst), .i_ena(w_ena), .i_re(w_re), .i_im(w_im), .o_abs(w_lane_abs[l]));
    end
  end

  // Slice tags ride alongside the magnitude pipeline so results land in the right slots.
  if (CABS_DELAY == 0) begin : g_tag_comb
    assign w_ret_vld = (r_state == CALC);
    assign w_ret_idx = r_slice;
  end else begin : g_tag_pipe
    logic [CABS_DELAY-1:0] r_tag_vld;
    logic [SW-1:0]         r_tag_idx [CABS_DELAY];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_tag_vld <= '0;
        for (int i = 0; i < CABS_DELAY; i++) r_tag_idx[i] <= '0;
      end else if (w_ena) begin
        r_tag_vld[0] <= (r_state == CALC);
        r_tag_idx[0] <= r_slice;
        for (int i = 1; i < CABS_DELAY; i++) begin
          r_tag_vld[i] <= r_tag_vld[i-1];
          r_tag_idx[i] <= r_tag_idx[i-1];
        end
      end
    end
    assign w_ret_vld = r_tag_vld[CABS_DELAY-1];
    assign w_ret_idx = r_tag_idx[CABS_DELAY-1];
  end

  always_comb begin
    w_abs_nxt = r_abs;
    if (w_ret_vld) begin
      for (int l = 0; l < NUM_LANES; l++)
        w_abs_nxt[(int'(w_ret_idx) * NUM_LANES + l) * CHANNEL_WIDTH +: CHANNEL_WIDTH] =
          CHANNEL_WIDTH'(w_lane_abs[l]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slice          <= '0;
      r_data           <= '0;
      r_last           <= 1'b0;
      r_abs            <= '0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tdata     <= '0;
      m_axis_tdata_abs <= '0;
      m_axis_tlast     <= 1'b0;
    end else begin
      r_abs <= w_abs_nxt;
      if (w_accept) begin
        r_data  <= s_axis_tdata;
        r_last  <= s_axis_tlast;
        r_slice <= '0;
        r_abs   <= '0;
      end else if (r_state == CALC && r_slice != LAST_SLICE) begin
        r_slice <= r_slice + 1'b1;
      end
      if (w_ret_final) begin
        m_axis_tvalid    <= 1'b1;
        m_axis_tdata     <= r_data;
        m_axis_tdata_abs <= w_abs_nxt;
        m_axis_tlast     <= r_last;
      end else if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef AXIS_CABS_PEAK_IDX_EN
  logic [ABS_WIDTH-1:0]   r_max, w_max_nxt, w_slice_max;
  logic [COUNT_WIDTH-1:0] r_max_idx, w_max_idx_nxt, r_tuser;
  int                     w_slice_lane;

  // Strict compares: lower lane wins inside a slice, earlier slice wins across slices.
  always_comb begin
    w_slice_max  = w_lane_abs[0];
    w_slice_lane = 0;
    for (int l = 1; l < NUM_LANES; l++) begin
      if (w_lane_abs[l] > w_slice_max) begin
        w_slice_max  = w_lane_abs[l];
        w_slice_lane = l;
      end
    end
    w_max_nxt     = r_max;
    w_max_idx_nxt = r_max_idx;
    if (w_ret_vld && w_slice_max > r_max) begin
      w_max_nxt     = w_slice_max;
      w_max_idx_nxt = COUNT_WIDTH'(int'(w_ret_idx) * NUM_LANES + w_slice_lane);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max     <= '0;
      r_max_idx <= '0;
      r_tuser   <= '0;
    end else begin
      if (w_accept) begin
        r_max     <= '0;
        r_max_idx <= '0;
      end else begin
        r_max     <= w_max_nxt;
        r_max_idx <= w_max_idx_nxt;
      end
      if (w_ret_final) r_tuser <= w_max_idx_nxt;
    end
  end

  assign m_axis_tuser = r_tuser;
`else
  assign m_axis_tuser = '0;
`endif
endmodule

// File: tb/tb_axis_cabs_multilane.sv
// tb/tb_axis_cabs_multilane.sv - directed + random bench for axis_cabs_multilane (4 ch, 2 lanes)
// Expected tuser follows AXIS_CABS_PEAK_IDX_EN when the bench is compiled.

module tb_axis_cabs_multilane;
  localparam int NC = 4;
  localparam int CW = 32;
  localparam int NL = 2;
  localparam int CD = 1;
  localparam int DW = NC * CW;
  localparam int LAT = 4;   // edges counted with the accepting edge as edge 1
  localparam int PERIOD = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          m_tvalid, m_tready = 1'b1, m_tlast;
  logic [DW-1:0] m_tdata, m_tabs;
  logic [1:0]    m_tuser;

  int n_chk = 0, n_fail = 0, cyc = 0, n_out = 0;
  int q_cyc[$];
  logic q_last[$];
  logic [DW-1:0] q_abs[$];

  axis_cabs_multilane #(.NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW), .NUM_LANES(NL), .CABS_DELAY(CD)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tdata_abs(m_tabs), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (m_tvalid && m_tready) begin
    n_out++;
    q_cyc.push_back(cyc);
    q_last.push_back(m_tlast);
    q_abs.push_back(m_tabs);
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int i, input int q);
    return {q[15:0], i[15:0]};
  endfunction

  // Reference: exact integer magnitude per channel, first strictly-larger channel is the peak.
  task automatic model(input logic [DW-1:0] d, output logic [DW-1:0] a, output int peak);
    longint best = -1;
    a = '0;
    peak = 0;
    for (int c = 0; c < NC; c++) begin
      int i, q;
      longint s, m;
      i = int'($signed(d[c*CW +: 16]));
      q = int'($signed(d[c*CW+16 +: 16]));
      s = longint'(i) * longint'(i) + longint'(q) * longint'(q);
      m = longint'($sqrt(real'(s)));
      while (m * m > s) m--;
      while ((m + 1) * (m + 1) <= s) m++;
      a[c*CW +: CW] = 32'(m);
      if (m > best) begin best = m; peak = c; end
    end
  endtask

  function automatic int exp_user(input int peak);
`ifdef AXIS_CABS_PEAK_IDX_EN
    return peak;
`else
    return 0 * peak;
`endif
  endfunction

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [15:0] rnd16();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'($urandom_range(0, 20)) - 16'd10;
      default: return r[15:0];
    endcase
  endfunction

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [DW-1:0] d, input logic l);
    bit ok = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_tready) begin ok = 1; break; end
    end
    chk("accept", DW'(ok), DW'(1));
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tdata = rnd128(); s_tlast = ~l;
  endtask

  // Entered just after the accepting edge; returns at the negedge where tvalid is high.
  task automatic wait_out(input logic [DW-1:0] d, input logic l);
    int lat = 1, peak;
    bit ok = 0;
    logic [DW-1:0] a;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (m_tvalid) begin ok = 1; break; end
      @(posedge clk); #1;
      lat++;
    end
    model(d, a, peak);
    chk("out_valid", DW'(ok), DW'(1));
    chk("latency", DW'(lat), DW'(LAT));
    chk("tdata", m_tdata, d);
    chk("tdata_abs", m_tabs, a);
    chk("tuser", DW'(m_tuser), DW'(exp_user(peak)));
    chk("tlast", DW'(m_tlast), DW'(l));
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_s_tready"}, DW'(s_tready), DW'(0));
    chk({tag, "_tvalid"}, DW'(m_tvalid), DW'(0));
    chk({tag, "_tdata"}, m_tdata, '0);
    chk({tag, "_abs"}, m_tabs, '0);
    chk({tag, "_tlast"}, DW'(m_tlast), DW'(0));
    chk({tag, "_tuser"}, DW'(m_tuser), DW'(0));
  endtask

  initial begin
    logic [DW-1:0] d1, d_ones, d_rst, da, db, ea, eb, e1;
    int n0, pka, pkb, pk1;

    d1     = {pk(-8, -6), pk(0, 0), pk(-5, 12), pk(3, 4)};
    d_ones = {pk(1, 0), pk(1, 0), pk(1, 0), pk(1, 0)};
    d_rst  = {pk(0, 0), pk(0, 7), pk(0, 0), pk(0, 0)};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", DW'(s_tready), DW'(1));
    @(posedge clk); #1;

    // Single beat, known magnitudes
    send(d1, 1'b1);
    wait_out(d1, 1'b1);
    chk("abs_known", m_tabs, {32'd10, 32'd0, 32'd13, 32'd5});
    chk("tuser_known", DW'(m_tuser), DW'(exp_user(1)));
    @(posedge clk); #1;

    // Backpressure: outputs frozen and no accept while held
    m_tready = 1'b0;
    send(d1, 1'b0);
    wait_out(d1, 1'b0);
    model(d1, e1, pk1);
    n0 = n_out;
    @(posedge clk); #1;
    s_tvalid = 1'b1; s_tdata = d_ones; s_tlast = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_tvalid", DW'(m_tvalid), DW'(1));
      chk("hold_tdata", m_tdata, d1);
      chk("hold_abs", m_tabs, e1);
      chk("hold_tlast", DW'(m_tlast), DW'(0));
      chk("hold_s_tready", DW'(s_tready), DW'(0));
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("hold_one_beat", DW'(n_out - n0), DW'(1));
    chk("hold_released", DW'(m_tvalid), DW'(0));
    @(posedge clk); #1;

    // Ties resolve to the lowest channel
    send(d_ones, 1'b0);
    wait_out(d_ones, 1'b0);
    chk("tie_tuser", DW'(m_tuser), DW'(0));
    @(posedge clk); #1;

    // Reset in CALC discards the beat
    n0 = n_out;
    send(rnd128(), 1'b1);
    rst = 1'b1;
    #1;
    check_idle_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    send(d_rst, 1'b0);
    wait_out(d_rst, 1'b0);
    chk("midrst_abs", m_tabs, {32'd0, 32'd7, 32'd0, 32'd0});
    chk("midrst_tuser", DW'(m_tuser), DW'(exp_user(2)));
    @(posedge clk); #1;
    chk("midrst_beats", DW'(n_out - n0), DW'(1));

    // Back-to-back throughput
    q_cyc.delete(); q_last.delete(); q_abs.delete();
    da = rnd128(); db = rnd128();
    model(da, ea, pka);
    model(db, eb, pkb);
    send(da, 1'b0);
    send(db, 1'b1);
    for (int k = 0; k < 40 && q_cyc.size() < 2; k++) @(posedge clk);
    #1;
    chk("b2b_count", DW'(q_cyc.size()), DW'(2));
    if (q_cyc.size() >= 2) begin
      chk("b2b_spacing", DW'(q_cyc[1] - q_cyc[0]), DW'(PERIOD));
      chk("b2b_tlast0", DW'(q_last[0]), DW'(0));
      chk("b2b_tlast1", DW'(q_last[1]), DW'(1));
      chk("b2b_abs0", q_abs[0], ea);
      chk("b2b_abs1", q_abs[1], eb);
    end
    @(posedge clk); #1;

    // Random beats against the reference model
    for (int n = 0; n < 16; n++) begin
      logic [DW-1:0] d;
      logic l;
      for (int c = 0; c < NC; c++) d[c*CW +: CW] = {rnd16(), rnd16()};
      l = 1'($urandom_range(0, 1));
      send(d, l);
      wait_out(d, l);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
